demod_stream_arbiter: RTL and testbench

- Packet-level 2:1 round-robin arbiter that shares one cordic→demodulate chain between two complex-sample AXI-Stream sources (e.g. two tuned channels).
- Sits directly upstream of the cordic input. Grants one source at a time and holds the grant until that source's tlast beat is transferred.
- Registers the selected beat onto a single master stream, tags it with the source channel id, and keeps per-channel packet counters for status.

---
 rtl/demod_stream_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_demod_stream_arbiter.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demod_stream_arbiter.sv
// ---------------------------------------------------------------------------
// demod_stream_arbiter
//
// Packet-level 2:1 round-robin arbiter placed in front of the shared
// cordic -> demodulate chain. One complex-sample AXI-Stream source is granted
// at a time, and the grant is held until that source's tlast beat has been
// accepted. Accepted beats are registered onto a single master stream and
// tagged with the source channel id. A completed-packet counter is kept for
// each channel.
//
// Ports
//   s00_axis_aclk      in   clock for all logic
//   s00_axis_areset    in   asynchronous reset, active-high
//   arb_enable         in   1 = new grants allowed, 0 = finish packet then stop
//   s00_axis_*         ch0 slave stream (tvalid/tlast/tdata/tstrb in, tready out)
//   s01_axis_*         ch1 slave stream (tvalid/tlast/tdata/tstrb in, tready out)
//   m00_axis_tready    in   downstream ready
//   m00_axis_*         registered master stream (tvalid/tlast/tdata/tstrb/tid)
//   busy               out  FSM is not in IDLE
//   pkt_count0/1       out  packets accepted per channel, wrapping counters
// ---------------------------------------------------------------------------
module demod_stream_arbiter #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_PKT_CNT_WIDTH        = 16
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_areset,
    input  logic                                  arb_enable,

    input  logic                                  s00_axis_tvalid,
    input  logic                                  s00_axis_tlast,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
    output logic                                  s00_axis_tready,

    input  logic                                  s01_axis_tvalid,
    input  logic                                  s01_axis_tlast,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s01_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s01_axis_tstrb,
    output logic                                  s01_axis_tready,

    input  logic                                  m00_axis_tready,
    output logic                                  m00_axis_tvalid,
    output logic                                  m00_axis_tlast,
    output logic [C_S00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                                  m00_axis_tid,

    output logic                                  busy,
    output logic [C_PKT_CNT_WIDTH-1:0]            pkt_count0,
    output logic [C_PKT_CNT_WIDTH-1:0]            pkt_count1
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2
    } state_t;

    state_t                                r_state;
    logic                                  r_last_grant;
    logic                                  r_busy;

    logic                                  r_m_tvalid;
    logic                                  r_m_tlast;
    logic [C_S00_AXIS_TDATA_WIDTH-1:0]     r_m_tdata;
    logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   r_m_tstrb;
    logic                                  r_m_tid;

    logic [C_PKT_CNT_WIDTH-1:0]            r_pkt_count0;
    logic [C_PKT_CNT_WIDTH-1:0]            r_pkt_count1;

    logic                                  w_out_free;
    logic                                  w_xfer0;
    logic                                  w_xfer1;

    // The output register can take a new beat when it is empty or is being
    // drained this cycle. Only the granted input sees that as tready, so the
    // two transfer strobes can never be high together.
    assign w_out_free      = !r_m_tvalid || m00_axis_tready;
    assign s00_axis_tready = (r_state == ST_G0) && w_out_free;
    assign s01_axis_tready = (r_state == ST_G1) && w_out_free;
    assign w_xfer0         = s00_axis_tvalid && s00_axis_tready;
    assign w_xfer1         = s01_axis_tvalid && s01_axis_tready;

    // Arbitration FSM. Grants are only issued from IDLE, so every packet
    // boundary costs one idle cycle. On a tie the channel that was not granted
    // last wins; r_last_grant resets to 1 so channel 0 wins the first tie.
    // busy is registered alongside the state it reflects.
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (arb_enable) begin
                        if (s00_axis_tvalid && (!s01_axis_tvalid || r_last_grant)) begin
                            r_state      <= ST_G0;
                            r_last_grant <= 1'b0;
                            r_busy       <= 1'b1;
                        end else if (s01_axis_tvalid) begin
                            r_state      <= ST_G1;
                            r_last_grant <= 1'b1;
                            r_busy       <= 1'b1;
                        end
                    end
                end
                ST_G0: begin
                    if (w_xfer0 && s00_axis_tlast) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_G1: begin
                    if (w_xfer1 && s01_axis_tlast) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Master output register. A beat is loaded only when the register is
    // free; while the downstream stalls a valid beat, everything holds.
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tstrb  <= '0;
            r_m_tid    <= 1'b0;
        end else if (w_out_free) begin
            if (w_xfer0) begin
                r_m_tvalid <= 1'b1;
                r_m_tlast  <= s00_axis_tlast;
                r_m_tdata  <= s00_axis_tdata;
                r_m_tstrb  <= s00_axis_tstrb;
                r_m_tid    <= 1'b0;
            end else if (w_xfer1) begin
                r_m_tvalid <= 1'b1;
                r_m_tlast  <= s01_axis_tlast;
                r_m_tdata  <= s01_axis_tdata;
                r_m_tstrb  <= s01_axis_tstrb;
                r_m_tid    <= 1'b1;
            end else begin
                r_m_tvalid <= 1'b0;
            end
        end
    end

    // Packet counters advance when the tlast beat is accepted from the input,
    // not when it leaves the output register.
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            r_pkt_count0 <= '0;
            r_pkt_count1 <= '0;
        end else begin
            if (w_xfer0 && s00_axis_tlast) begin
                r_pkt_count0 <= r_pkt_count0 + C_PKT_CNT_WIDTH'(1);
            end
            if (w_xfer1 && s01_axis_tlast) begin
                r_pkt_count1 <= r_pkt_count1 + C_PKT_CNT_WIDTH'(1);
            end
        end
    end

    assign m00_axis_tvalid = r_m_tvalid;
    assign m00_axis_tlast  = r_m_tlast;
    assign m00_axis_tdata  = r_m_tdata;
    assign m00_axis_tstrb  = r_m_tstrb;
    assign m00_axis_tid    = r_m_tid;
    assign busy            = r_busy;
    assign pkt_count0      = r_pkt_count0;
    assign pkt_count1      = r_pkt_count1;

endmodule

// File: tb/tb_demod_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_demod_stream_arbiter
//
// Directed testbench for demod_stream_arbiter. Inputs are driven 1 time unit
// after each rising edge and outputs are sampled at that point, away from the
// active edge. Packet counters are narrowed to 3 bits so wrap-around can be
// reached with a handful of packets.
// ---------------------------------------------------------------------------
module tb_demod_stream_arbiter;

    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          arbEnable;

    logic          s0Valid;
    logic          s0Last;
    logic [DW-1:0] s0Data;
    logic [SW-1:0] s0Strb;
    logic          s0Ready;

    logic          s1Valid;
    logic          s1Last;
    logic [DW-1:0] s1Data;
    logic [SW-1:0] s1Strb;
    logic          s1Ready;

    logic          mReady;
    logic          mValid;
    logic          mLast;
    logic [DW-1:0] mData;
    logic [SW-1:0] mStrb;
    logic          mId;

    logic          busy;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;

    int checks = 0;
    int errors = 0;

    // 10-unit clock period
    always #5 clk = ~clk;

    demod_stream_arbiter #(
        .C_S00_AXIS_TDATA_WIDTH (DW),
        .C_PKT_CNT_WIDTH        (CW)
    ) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .arb_enable      (arbEnable),
        .s00_axis_tvalid (s0Valid),
        .s00_axis_tlast  (s0Last),
        .s00_axis_tdata  (s0Data),
        .s00_axis_tstrb  (s0Strb),
        .s00_axis_tready (s0Ready),
        .s01_axis_tvalid (s1Valid),
        .s01_axis_tlast  (s1Last),
        .s01_axis_tdata  (s1Data),
        .s01_axis_tstrb  (s1Strb),
        .s01_axis_tready (s1Ready),
        .m00_axis_tready (mReady),
        .m00_axis_tvalid (mValid),
        .m00_axis_tlast  (mLast),
        .m00_axis_tdata  (mData),
        .m00_axis_tstrb  (mStrb),
        .m00_axis_tid    (mId),
        .busy            (busy),
        .pkt_count0      (cnt0),
        .pkt_count1      (cnt1)
    );

    // Safety net so the run always ends even if a loop bound is wrong
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

    // Quiet values for every DUT input
    task automatic idleInputs();
        arbEnable = 1'b0;
        s0Valid = 1'b0; s0Last = 1'b0; s0Data = '0; s0Strb = '0;
        s1Valid = 1'b0; s1Last = 1'b0; s1Data = '0; s1Strb = '0;
        mReady  = 1'b1;
    endtask

    // Advance one clock and step just past the edge
    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset across two edges and release just after an edge
    task automatic doReset();
        rst = 1'b1;
        idleInputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Expected/driven data word for the round-robin scenario
    function automatic logic [31:0] rrData(input int ch, input int p, input int b);
        logic [31:0] base;
        base = (ch == 0) ? 32'hA000_0000 : 32'hB000_0000;
        return base | (32'(p) << 8) | 32'(b + 1);
    endfunction

    // Outputs must be cleared while reset is held, even with a source requesting
    task automatic test_reset();
        rst = 1'b1;
        idleInputs();
        arbEnable = 1'b1;
        s0Valid = 1'b1; s0Data = 32'hDEAD_BEEF; s0Strb = 4'hF;
        s1Valid = 1'b1; s1Data = 32'h1234_5678; s1Strb = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({mValid, mLast, mId, mData, mStrb} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_m00: got %h expected 0", {mValid, mLast, mId, mData, mStrb});
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if ({cnt0, cnt1} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_counts: got %h/%h expected 0/0", cnt0, cnt1);
        end
        checks++;
        if ({s0Ready, s1Ready} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_tready: got %b expected 00", {s0Ready, s1Ready});
        end
        idleInputs();
        rst = 1'b0;
    endtask

    // One 4-beat ch0 packet, downstream always ready
    task automatic test_single_channel();
        logic [31:0] expData;
        doReset();
        arbEnable = 1'b1;
        s0Valid = 1'b1; s0Data = 32'h0001_0001; s0Strb = 4'hF; s0Last = 1'b0;
        nextEdge();
        checks++;
        if ({busy, s0Ready, s1Ready, mValid} !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL single_grant: got %b expected 1100", {busy, s0Ready, s1Ready, mValid});
        end
        for (int i = 1; i <= 4; i++) begin
            nextEdge();
            if (i < 4) begin
                s0Data = 32'(i + 1) * 32'h0001_0001;
                s0Last = (i + 1 == 4);
            end else begin
                s0Valid = 1'b0;
                s0Last  = 1'b0;
            end
            expData = 32'(i) * 32'h0001_0001;
            checks++;
            if ({mValid, mLast, mId, mData, mStrb} !== {1'b1, (i == 4), 1'b0, expData, 4'hF}) begin
                errors++;
                $display("[TB] FAIL single_beat%0d: got v%b l%b id%b %h expected v1 l%b id0 %h",
                         i, mValid, mLast, mId, mData, (i == 4), expData);
            end
            checks++;
            if (s1Ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL single_s01_tready: got %b expected 0", s1Ready);
            end
        end
        checks++;
        if ({busy, cnt0, cnt1} !== {1'b0, 3'd1, 3'd0}) begin
            errors++;
            $display("[TB] FAIL single_end: got busy%b c0=%0d c1=%0d expected busy0 c0=1 c1=0",
                     busy, cnt0, cnt1);
        end
        nextEdge();
        checks++;
        if (mValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_drain: got tvalid %b expected 0", mValid);
        end
    endtask

    // Both channels offer two 3-beat packets each; output must alternate
    task automatic test_round_robin();
        logic [31:0] outData [12];
        logic        outLast [12];
        logic        outId   [12];
        int          outCyc  [12];
        int          nOut;
        int          b0, p0, b1, p1;
        logic        x0, x1;
        int          j;
        doReset();
        arbEnable = 1'b1;
        b0 = 0; p0 = 0; b1 = 0; p1 = 0;
        nOut = 0;
        s0Strb = 4'hF; s1Strb = 4'hF;
        s0Valid = 1'b1; s0Data = rrData(0, p0, b0); s0Last = 1'b0;
        s1Valid = 1'b1; s1Data = rrData(1, p1, b1); s1Last = 1'b0;
        for (int cyc = 0; cyc < 60 && nOut < 12; cyc++) begin
            if (mValid && mReady) begin
                outData[nOut] = mData;
                outLast[nOut] = mLast;
                outId[nOut]   = mId;
                outCyc[nOut]  = cyc;
                nOut++;
            end
            x0 = s0Valid && s0Ready;
            x1 = s1Valid && s1Ready;
            nextEdge();
            if (x0) begin
                if (b0 == 2) begin b0 = 0; p0++; end else b0++;
            end
            if (x1) begin
                if (b1 == 2) begin b1 = 0; p1++; end else b1++;
            end
            s0Valid = (p0 < 2); s0Data = rrData(0, p0, b0); s0Last = (b0 == 2);
            s1Valid = (p1 < 2); s1Data = rrData(1, p1, b1); s1Last = (b1 == 2);
        end
        checks++;
        if (nOut != 12) begin
            errors++;
            $display("[TB] FAIL rr_beat_count: got %0d expected 12", nOut);
        end
        for (int k = 0; k < nOut; k++) begin
            j = k / 3;
            checks++;
            if ({outId[k], outLast[k], outData[k]} !== {1'(j % 2), (k % 3 == 2), rrData(j % 2, j / 2, k % 3)}) begin
                errors++;
                $display("[TB] FAIL rr_beat%0d: got id%b l%b %h expected id%0d l%b %h",
                         k, outId[k], outLast[k], outData[k], j % 2, (k % 3 == 2), rrData(j % 2, j / 2, k % 3));
            end
            if (k > 0) begin
                checks++;
                if (outCyc[k] - outCyc[k-1] != ((k % 3 == 0) ? 2 : 1)) begin
                    errors++;
                    $display("[TB] FAIL rr_spacing%0d: got %0d expected %0d",
                             k, outCyc[k] - outCyc[k-1], (k % 3 == 0) ? 2 : 1);
                end
            end
        end
        checks++;
        if ({cnt0, cnt1} !== {3'd2, 3'd2}) begin
            errors++;
            $display("[TB] FAIL rr_counts: got %0d/%0d expected 2/2", cnt0, cnt1);
        end
        idleInputs();
    endtask

    // ch1 4-beat packet with downstream stalls, including a stall on tlast
    task automatic test_stall();
        logic [15:0] rdyPat;
        int          b;
        int          e;
        logic        x1;
        logic [31:0] expData;
        doReset();
        arbEnable = 1'b1;
        rdyPat = 16'hFF67;
        b = 0; e = 0;
        s1Valid = 1'b1; s1Data = 32'hC000_0001; s1Strb = 4'h3; s1Last = 1'b0;
        for (int c = 0; c < 40 && e < 4; c++) begin
            mReady = (c < 16) ? rdyPat[c] : 1'b1;
            #0;
            if (mValid) begin
                expData = 32'hC000_0000 | 32'(e + 1);
                checks++;
                if ({mLast, mId, mData, mStrb} !== {(e == 3), 1'b1, expData, 4'h3}) begin
                    errors++;
                    $display("[TB] FAIL stall_beat%0d_cyc%0d: got l%b id%b %h s%h expected l%b id1 %h s3",
                             e, c, mLast, mId, mData, mStrb, (e == 3), expData);
                end
                if (!mReady) begin
                    checks++;
                    if (s1Ready !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL stall_tready_cyc%0d: got %b expected 0", c, s1Ready);
                    end
                end else begin
                    e++;
                end
            end
            x1 = s1Valid && s1Ready;
            nextEdge();
            if (x1) b++;
            s1Valid = (b < 4);
            s1Data  = 32'hC000_0000 | 32'(b + 1);
            s1Last  = (b == 3);
        end
        checks++;
        if (e != 4) begin
            errors++;
            $display("[TB] FAIL stall_delivered: got %0d beats expected 4", e);
        end
        mReady = 1'b1;
        nextEdge();
        checks++;
        if (mValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_extra_beat: got tvalid %b expected 0", mValid);
        end
        checks++;
        if ({cnt0, cnt1} !== {3'd0, 3'd1}) begin
            errors++;
            $display("[TB] FAIL stall_counts: got %0d/%0d expected 0/1", cnt0, cnt1);
        end
        idleInputs();
    endtask

    // arb_enable drops during a 5-beat ch0 packet while ch1 waits
    task automatic test_enable_drop();
        doReset();
        arbEnable = 1'b1;
        s0Valid = 1'b1; s0Data = 32'h0E00_0001; s0Strb = 4'hF; s0Last = 1'b0;
        s1Valid = 1'b1; s1Data = 32'h0E11_0001; s1Strb = 4'hF; s1Last = 1'b1;
        nextEdge();
        checks++;
        if ({s0Ready, s1Ready} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL en_first_grant: got %b expected 10", {s0Ready, s1Ready});
        end
        for (int i = 1; i <= 5; i++) begin
            nextEdge();
            if (i == 1) arbEnable = 1'b0;
            if (i < 5) begin
                s0Data = 32'h0E00_0000 | 32'(i + 1);
                s0Last = (i + 1 == 5);
            end else begin
                s0Valid = 1'b0;
                s0Last  = 1'b0;
            end
            checks++;
            if ({mValid, mLast, mId, mData} !== {1'b1, (i == 5), 1'b0, 32'h0E00_0000 | 32'(i)}) begin
                errors++;
                $display("[TB] FAIL en_beat%0d: got v%b l%b id%b %h expected v1 l%b id0 %h",
                         i, mValid, mLast, mId, mData, (i == 5), 32'h0E00_0000 | 32'(i));
            end
            checks++;
            if (s1Ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL en_s01_tready_beat%0d: got %b expected 0", i, s1Ready);
            end
        end
        for (int w = 0; w < 3; w++) begin
            nextEdge();
            checks++;
            if ({busy, s1Ready, mValid} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL en_disabled_wait%0d: got busy/rdy/valid %b expected 000",
                         w, {busy, s1Ready, mValid});
            end
        end
        arbEnable = 1'b1;
        nextEdge();
        checks++;
        if ({busy, s1Ready, s0Ready} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL en_resume_grant: got %b expected 110", {busy, s1Ready, s0Ready});
        end
        nextEdge();
        s1Valid = 1'b0;
        checks++;
        if ({mValid, mLast, mId, mData} !== {1'b1, 1'b1, 1'b1, 32'h0E11_0001}) begin
            errors++;
            $display("[TB] FAIL en_ch1_beat: got v%b l%b id%b %h expected v1 l1 id1 0e110001",
                     mValid, mLast, mId, mData);
        end
        checks++;
        if ({cnt0, cnt1} !== {3'd1, 3'd1}) begin
            errors++;
            $display("[TB] FAIL en_counts: got %0d/%0d expected 1/1", cnt0, cnt1);
        end
        idleInputs();
    endtask

    // Nine single-beat ch0 packets: 3-bit counter wraps 7 -> 0 -> 1
    task automatic test_wrap();
        logic [CW-1:0] expCnt;
        doReset();
        arbEnable = 1'b1;
        s0Valid = 1'b1; s0Last = 1'b1; s0Strb = 4'hF; s0Data = 32'h0000_0001;
        for (int k = 1; k <= 9; k++) begin
            nextEdge();
            checks++;
            if ({busy, s0Ready} !== 2'b11) begin
                errors++;
                $display("[TB] FAIL wrap_grant%0d: got %b expected 11", k, {busy, s0Ready});
            end
            nextEdge();
            s0Data = 32'(k + 1);
            expCnt = CW'(k);
            checks++;
            if ({busy, mValid, mLast, mData, cnt0} !== {1'b0, 1'b1, 1'b1, 32'(k), expCnt}) begin
                errors++;
                $display("[TB] FAIL wrap_pkt%0d: got busy%b v%b l%b %h cnt%0d expected busy0 v1 l1 %h cnt%0d",
                         k, busy, mValid, mLast, mData, cnt0, 32'(k), expCnt);
            end
        end
        s0Valid = 1'b0;
        s0Last  = 1'b0;
    endtask

    // Reset asserted between edges during beat 3 of a ch0 packet
    task automatic test_reset_mid();
        arbEnable = 1'b1;
        s0Valid = 1'b1; s0Last = 1'b0; s0Strb = 4'hF; s0Data = 32'h0D00_0001;
        nextEdge();
        for (int i = 1; i <= 3; i++) begin
            nextEdge();
            s0Data = 32'h0D00_0000 | 32'(i + 1);
        end
        checks++;
        if ({mValid, busy, mData, cnt0} !== {1'b1, 1'b1, 32'h0D00_0003, 3'd1}) begin
            errors++;
            $display("[TB] FAIL rmid_before: got v%b busy%b %h cnt%0d expected v1 busy1 0d000003 cnt1",
                     mValid, busy, mData, cnt0);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({mValid, busy, s0Ready, cnt0, cnt1} !== {1'b0, 1'b0, 1'b0, 3'd0, 3'd0}) begin
            errors++;
            $display("[TB] FAIL rmid_async_clear: got v%b busy%b rdy%b cnt%0d/%0d expected all 0",
                     mValid, busy, s0Ready, cnt0, cnt1);
        end
        #2;
        rst = 1'b0;
        s0Data = 32'h0D0D_0000; s0Last = 1'b1;
        s1Valid = 1'b1; s1Data = 32'h0D1D_0000; s1Last = 1'b1; s1Strb = 4'hF;
        nextEdge();
        checks++;
        if ({busy, s0Ready, s1Ready} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL rmid_tie_grant: got %b expected 110", {busy, s0Ready, s1Ready});
        end
        nextEdge();
        s0Valid = 1'b0;
        s1Valid = 1'b0;
        checks++;
        if ({mValid, mId, mData} !== {1'b1, 1'b0, 32'h0D0D_0000}) begin
            errors++;
            $display("[TB] FAIL rmid_tie_beat: got v%b id%b %h expected v1 id0 0d0d0000",
                     mValid, mId, mData);
        end
        idleInputs();
    endtask

    // Scenario sequence
    initial begin
        idleInputs();
        rst = 1'b1;
        test_reset();
        test_single_channel();
        test_round_robin();
        test_stall();
        test_enable_drop();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
